offset_estimator: RTL
=====================

# offset_estimator

Background DC-offset calibration stage for the saturating offset adder. It averages 2^K two's-complement samples of the raw data stream and presents the negated, saturated mean as an N-bit correction word. That word drives the adder's Offset input directly, so the adder's output is nulled to zero mean. Calibration runs on request; the previous correction is held stable until the new one is ready.

## Interface
Parameters:
- N, 8, data and offset width (two's complement); N ≥ 2
- K, 10, log2 of number of samples averaged; K ≥ 1

Ports (clock and reset first; the block uses one clock, and reset is synchronous and active-high):
- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- Data  input  N  raw sample, two's complement (same stream fed to the adder's Data)
- Valid  input  1  Data qualifier, one sample per high cycle
- Start  input  1  request a calibration run (level sampled each cycle)
- Offset  output  N  correction word = −mean(Data), saturated, two's complement, registered
- Busy  output  1  high while a run is in progress
- Done  output  1  one-cycle pulse when Offset is updated

## Operation
- States: IDLE, ACCUM, FINISH.
- IDLE:
  - Start=1 → clear accumulator and sample counter; go to ACCUM; Busy=1 from the next cycle.
  - Valid is ignored in IDLE.
  - A Valid coincident with Start is not accumulated.
- ACCUM:
  - Each Valid=1 cycle adds sign-extended Data to the accumulator and increments the counter.
  - Valid=0 cycles hold state; gaps of any length are allowed.
  - When the 2^K-th sample is accepted (counter = 2^K−1 with Valid=1), go to FINISH.
- FINISH (one cycle):
  - Compute mean = accumulator >>> K (arithmetic shift), then negate it.
  - If mean = −2^(N−1), output 2^(N−1)−1; otherwise output −mean.
  - Register the result into Offset, pulse Done, drop Busy, return to IDLE.
- Arithmetic:
  - Accumulator is signed, N+K+1 bits. It cannot overflow for any input, rounding term included.
  - The mean always fits in N bits; the only saturation case is negating the most negative value.
- Start is ignored while Busy=1 and during the Done cycle's edge. A new run can begin in the cycle after Done.
- Offset changes only at the FINISH edge or on Reset. It is stable throughout a run.

## Timing
- Reset values: Offset=0, Busy=0, Done=0, state IDLE, accumulator=0, counter=0.
- Reset mid-run aborts immediately with the same values. No Done pulse is produced and the partial sum is discarded.
- Start sampled high at edge s → Busy high from edge s.
- Last sample accepted at edge t → FINISH during cycle t..t+1 → at edge t+1: Offset updated, Done=1, Busy=0.
- Done deasserts at edge t+2.
- Minimum run length: 2^K + 1 cycles from Start edge to Done edge when Valid is continuous.
- Reset has priority over all other inputs on the same edge.

## Configuration
- Macro OFFSET_ESTIMATOR_ROUND_EN.
- Defined: add 2^(K−1) to the accumulator before the >>> K, giving round-half-up.
- Undefined: plain arithmetic shift, giving floor (round toward −∞).
- All other behaviour is identical in both builds.

## Test plan
Scenarios use N=8, K=4 unless stated.
- Reset: hold Reset for 2 cycles, mid-stream → Offset=8'h00, Busy=0, Done=0. Valid pulses in IDLE leave all outputs unchanged.
- Constant input: Start, then 16 Valid samples of +10 → Offset=8'hF6 (−10) at edge t+1. Done high exactly one cycle; Busy low from the same edge.
- Saturation: 16 samples of −128 → Offset=8'h7F. Then 16 samples of +127 → Offset=8'h81.
- Rounding, positive: 8×0 then 8×1 (sum 8) → Offset=8'hFF with ROUND_EN; Offset=8'h00 without.
- Rounding, negative: 8×(−1) then 8×0 (sum −8) → Offset=8'h00 with ROUND_EN; Offset=8'h01 without.
- Gaps and hold:
  - Valid toggling at random with 16 samples of +3 → Offset=8'hFD.
  - Offset keeps its prior value until Done.
  - Start pulses during Busy do not restart the run or change the sample count.
- Abort: Reset after 5 accepted samples → IDLE, Offset=8'h00, no Done. A fresh Start plus 16×(−4) → Offset=8'h04.

Source files
------------

// File: rtl/offset_estimator.sv
// offset_estimator: background DC-offset calibration.
// Averages 2^K signed samples and presents the negated, saturated mean
// as an N-bit correction word for the saturating offset adder.
// Optional build macro: OFFSET_ESTIMATOR_ROUND_EN selects round-half-up
// for the mean; when it is undefined the mean is floored (toward -inf).
module offset_estimator #(
  parameter int N = 8,
  parameter int K = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] Data,
  input  logic         Valid,
  input  logic         Start,
  output logic [N-1:0] Offset,
  output logic         Busy,
  output logic         Done
);

  // Accumulator wide enough for 2^K extreme samples plus the rounding term.
  localparam int AW = N + K + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

`ifdef OFFSET_ESTIMATOR_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'(1 << (K - 1));
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};

  logic [1:0]           state_q,  state_d;
  logic signed [AW-1:0] acc_q,    acc_d;
  logic [K-1:0]         cnt_q,    cnt_d;
  logic [N-1:0]         offset_q, offset_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;

  logic [N-1:0]         mean;

  // Mean of the run: low N bits of the (optionally rounded) arithmetic shift.
  // The full-width shift always fits in N bits, so the truncation is exact.
  always_comb begin
    mean = N'((acc_q + RND) >>> K);
  end

  // Next-state logic for the calibration FSM and datapath.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Valid is ignored here, including a Valid coincident with Start.
        if (Start) begin
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (Valid) begin
          acc_d = acc_q + {{(AW-N){Data[N-1]}}, Data};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = FINISH;
        end
      end
      FINISH: begin
        // Negating the most negative mean is the only overflow case.
        offset_d = (mean == MIN_NEG) ? MAX_POS : (~mean + 1'b1);
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset wins over every other input and aborts a run.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      offset_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Offset = offset_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule
